multicycle_ctrl: RTL

Main sequencing FSM for the multi-cycle RV32I core. It steps each instruction through FETCH, DECODE, EXEC, MEM and WB. It generates the per-cycle datapath strobes (PC/IR/regfile write, memory read/write, mux selects) and handshakes with a shared instruction/data memory port via mem_ready. It also keeps cycle and retired-instruction counters and halts on illegal opcodes or memory timeouts.

---
 rtl/multicycle_ctrl.sv | 283 ++++++++++++++++++++++++++++
 1 files changed

// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl
// Main sequencing FSM for the multi-cycle RV32I core. Each instruction walks
// FETCH -> DECODE -> EXEC -> (MEM) -> (WB) and the controller produces the
// per-cycle datapath strobes, waits on the shared memory port via mem_ready,
// counts cycles and retired instructions, and parks in HALT on an illegal
// opcode or a memory request that never completes.

module multicycle_ctrl #(
    parameter int CNT_W       = 32,
    parameter int MEM_TIMEOUT = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [6:0]       opcode,
    input  logic             branch_taken,
    input  logic             mem_ready,
    output logic             mem_read,
    output logic             mem_write,
    output logic             ir_we,
    output logic             pc_we,
    output logic             pc_src,
    output logic             reg_we,
    output logic [1:0]       result_src,
    output logic [1:0]       alu_src_b,
    output logic [2:0]       state,
    output logic             illegal,
    output logic             bus_err,
    output logic [CNT_W-1:0] cycle_count,
    output logic [CNT_W-1:0] instret_count
);

    // ------------------------------------------------------------------
    // Encodings
    // ------------------------------------------------------------------
    localparam logic [2:0] S_FETCH  = 3'd0;
    localparam logic [2:0] S_DECODE = 3'd1;
    localparam logic [2:0] S_EXEC   = 3'd2;
    localparam logic [2:0] S_MEM    = 3'd3;
    localparam logic [2:0] S_WB     = 3'd4;
    localparam logic [2:0] S_HALT   = 3'd5;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_IALU   = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

    localparam logic [1:0] RES_ALU = 2'b00;
    localparam logic [1:0] RES_MEM = 2'b01;
    localparam logic [1:0] RES_PC4 = 2'b10;

    localparam logic [1:0] ALU_B_RS2 = 2'b00;
    localparam logic [1:0] ALU_B_IMM = 2'b01;

    // The wait counter only ever holds 0 .. MEM_TIMEOUT-1: the cycle that
    // would take it to MEM_TIMEOUT is the timeout cycle itself.
    localparam int              WAIT_W    = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_TIMEOUT - 1);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [2:0]        state_q;
    logic [2:0]        state_d;
    logic [6:0]        op_q;
    logic [WAIT_W-1:0] wait_q;
    logic [WAIT_W-1:0] wait_d;
    logic              illegal_q;
    logic              bus_err_q;
    logic [CNT_W-1:0]  cycle_q;
    logic [CNT_W-1:0]  instret_q;

    logic              mem_wait;     // memory request outstanding and not served
    logic              timeout;      // this wait cycle is the last one allowed
    logic              retire;       // final cycle of the current instruction
    logic              set_illegal;

    // Raw strobes before the reset gate
    logic              mem_read_c;
    logic              mem_write_c;
    logic              ir_we_c;
    logic              pc_we_c;
    logic              pc_src_c;
    logic              reg_we_c;
    logic [1:0]        result_src_c;
    logic [1:0]        alu_src_b_c;

    function automatic logic is_supported(input logic [6:0] op);
        case (op)
            OP_R, OP_IALU, OP_LOAD, OP_STORE,
            OP_BRANCH, OP_LUI, OP_JAL: is_supported = 1'b1;
            default:                   is_supported = 1'b0;
        endcase
    endfunction

    // Memory wait tracking: only FETCH and MEM issue requests.
    always_comb begin
        mem_wait = ((state_q == S_FETCH) || (state_q == S_MEM)) && !mem_ready;
        timeout  = mem_wait && (wait_q == WAIT_LAST);
    end

    // Next-state, retire and wait-counter logic.
    always_comb begin
        // NOTE: every signal gets a default before the case so no path
        // leaves it unassigned; a missing default here infers a latch.
        state_d     = state_q;
        retire      = 1'b0;
        set_illegal = 1'b0;
        wait_d      = '0;

        case (state_q)
            S_FETCH: begin
                if (mem_ready) begin
                    state_d = S_DECODE;
                end else if (timeout) begin
                    state_d = S_HALT;
                end
            end

            S_DECODE: begin
                if (is_supported(opcode)) begin
                    state_d = S_EXEC;
                end else begin
                    state_d     = S_HALT;
                    set_illegal = 1'b1;
                end
            end

            S_EXEC: begin
                case (op_q)
                    OP_R, OP_IALU, OP_LUI: state_d = S_WB;
                    OP_LOAD, OP_STORE:     state_d = S_MEM;
                    OP_BRANCH, OP_JAL: begin
                        state_d = S_FETCH;
                        retire  = 1'b1;
                    end
                    // op_q is always a supported opcode once EXEC is reached
                    default:               state_d = S_HALT;
                endcase
            end

            S_MEM: begin
                if (mem_ready) begin
                    if (op_q == OP_LOAD) begin
                        state_d = S_WB;
                    end else begin
                        state_d = S_FETCH;
                        retire  = 1'b1;
                    end
                end else if (timeout) begin
                    state_d = S_HALT;
                end
            end

            S_WB: begin
                state_d = S_FETCH;
                retire  = 1'b1;
            end

            S_HALT:  state_d = S_HALT;
            default: state_d = S_HALT;
        endcase

        // Count unserved request cycles; any served cycle or state exit clears.
        if (mem_wait && !timeout) begin
            wait_d = wait_q + WAIT_W'(1);
        end
    end

    // Datapath strobes and mux selects decoded from the current state.
    always_comb begin
        mem_read_c   = 1'b0;
        mem_write_c  = 1'b0;
        ir_we_c      = 1'b0;
        pc_we_c      = 1'b0;
        pc_src_c     = 1'b0;
        reg_we_c     = 1'b0;
        result_src_c = RES_ALU;
        alu_src_b_c  = ALU_B_RS2;

        case (state_q)
            S_FETCH: begin
                // Request held until served; IR and PC+4 latch on the served cycle.
                mem_read_c = 1'b1;
                ir_we_c    = mem_ready;
                pc_we_c    = mem_ready;
            end

            S_EXEC: begin
                case (op_q)
                    OP_R: alu_src_b_c = ALU_B_RS2;
                    OP_IALU, OP_LOAD, OP_STORE, OP_LUI: alu_src_b_c = ALU_B_IMM;
                    OP_BRANCH: begin
                        pc_we_c  = branch_taken;
                        pc_src_c = 1'b1;
                    end
                    OP_JAL: begin
                        reg_we_c     = 1'b1;
                        result_src_c = RES_PC4;
                        pc_we_c      = 1'b1;
                        pc_src_c     = 1'b1;
                    end
                    default: ;
                endcase
            end

            S_MEM: begin
                if (op_q == OP_LOAD) begin
                    mem_read_c = 1'b1;
                end else begin
                    mem_write_c = 1'b1;
                end
            end

            S_WB: begin
                reg_we_c     = 1'b1;
                result_src_c = (op_q == OP_LOAD) ? RES_MEM : RES_ALU;
            end

            default: ;
        endcase
    end

    // Reset sits in FETCH, which would otherwise request memory; gate every
    // output with rst so nothing reaches the bus or the datapath during reset.
    assign mem_read   = rst & mem_read_c;
    assign mem_write  = rst & mem_write_c;
    assign ir_we      = rst & ir_we_c;
    assign pc_we      = rst & pc_we_c;
    assign pc_src     = rst & pc_src_c;
    assign reg_we     = rst & reg_we_c;
    assign result_src = rst ? result_src_c : 2'b00;
    assign alu_src_b  = rst ? alu_src_b_c  : 2'b00;

    // FSM state, latched opcode, wait counter and sticky error flags.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= S_FETCH;
            op_q      <= '0;
            wait_q    <= '0;
            illegal_q <= 1'b0;
            bus_err_q <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples the
            // pre-edge values; blocking here would create ordering races.
            state_q <= state_d;
            wait_q  <= wait_d;
            if (state_q == S_DECODE) begin
                op_q <= opcode;
            end
            if (set_illegal) begin
                illegal_q <= 1'b1;
            end
            if (timeout) begin
                bus_err_q <= 1'b1;
            end
        end
    end

    // Performance counters: cycles run until HALT, retires on final cycles.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cycle_q   <= '0;
            instret_q <= '0;
        end else begin
            if (state_q != S_HALT) begin
                cycle_q <= cycle_q + CNT_W'(1);
            end
            if (retire) begin
                instret_q <= instret_q + CNT_W'(1);
            end
        end
    end

    assign state         = state_q;
    assign illegal       = illegal_q;
    assign bus_err       = bus_err_q;
    assign cycle_count   = cycle_q;
    assign instret_count = instret_q;

endmodule
